// File: rtl/rto_pkg.sv
// rto_pkg: register map, FIFO entry layout and sequencer states shared by rto_core
package rto_pkg;
  localparam logic [4:0] ADDR_TS_LO  = 5'd0;
  localparam logic [4:0] ADDR_TS_HI  = 5'd1;
  localparam logic [4:0] ADDR_PUSH   = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_HEAD   = 5'd4;
  localparam logic [4:0] ADDR_FLUSH  = 5'd5;
  localparam logic [4:0] ADDR_CLEAR  = 5'd6;
  typedef struct packed {
    logic [31:0] ts_upper;
    logic [31:0] ts_lower;
    logic [31:0] data;
  } rto_entry_t;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, SHIFT} rto_state_t;
endpackage

// File: rtl/rto_event_fifo.sv
// rto_event_fifo: single-clock event FIFO with flush; read data is registered on pop
module rto_event_fifo #(
  parameter int DATA_WIDTH = 96,
  parameter int LOGDEPTH   = 4
) (
  input  logic                  clkx8,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);
  logic [DATA_WIDTH-1:0] r_mem [2**LOGDEPTH];
  logic [LOGDEPTH:0] r_wr_ptr, r_rd_ptr;
  logic w_push, w_pop;
  assign o_empty = r_wr_ptr == r_rd_ptr;
  assign o_full  = r_wr_ptr == {~r_rd_ptr[LOGDEPTH], r_rd_ptr[LOGDEPTH-1:0]};
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  always_ff @(posedge clkx8)
    if (w_push) r_mem[r_wr_ptr[LOGDEPTH-1:0]] <= i_data;
  always_ff @(posedge clkx8)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_data   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      o_data   <= w_pop ? r_mem[r_rd_ptr[LOGDEPTH-1:0]] : o_data;
    end
endmodule

// File: rtl/rto_core.sv
// rto_core: plays queued 32-bit words onto dout at 64-bit timestamps; RTO_LATE_DETECT_EN discards late events
module rto_core
  import rto_pkg::*;
#(
  parameter int N_OUT    = 4,
  parameter int LOGDEPTH = 4
) (
  input  logic             clkx8,
  input  logic             reset,
  input  logic             cs,
  input  logic             write,
  input  logic             read,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [63:0]      counter,
  output logic [N_OUT-1:0] dout
);
  localparam int NSLICE = 32 / N_OUT;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  rto_state_t r_state;
  logic [31:0] r_ts_lower, r_ts_upper, r_head_data;
  logic [63:0] r_head_ts;
  logic [IW-1:0] r_idx;
  logic r_overflow, r_late;
  logic w_wr, w_push, w_flush, w_clear, w_pop, w_full, w_empty, w_fire, w_late;
  rto_entry_t w_in, w_head;
  assign w_wr    = cs & write;
  assign w_push  = w_wr & (addr == ADDR_PUSH);
  assign w_flush = w_wr & (addr == ADDR_FLUSH);
  assign w_clear = w_wr & (addr == ADDR_CLEAR);
  assign w_pop   = (r_state == IDLE) & ~w_empty & ~w_flush;
  assign w_in    = '{ts_upper: r_ts_upper, ts_lower: r_ts_lower, data: wr_data};
`ifdef RTO_LATE_DETECT_EN
  assign w_late = counter > r_head_ts;
  assign w_fire = counter == r_head_ts;
`else
  assign w_late = 1'b0;
  assign w_fire = counter >= r_head_ts;
`endif
  assign rd_data = ~(cs & read)          ? 32'h0 :
                   addr == ADDR_STATUS   ? {28'h0, r_overflow, r_late, w_full, w_empty} :
                   addr == ADDR_HEAD     ? r_head_ts[31:0] : 32'h0;
  rto_event_fifo #(.DATA_WIDTH($bits(rto_entry_t)), .LOGDEPTH(LOGDEPTH)) u_fifo (
    .clkx8   (clkx8),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clkx8)
    if (reset) begin
      r_ts_lower <= '0;
      r_ts_upper <= '0;
    end else begin
      r_ts_lower <= (w_wr && addr == ADDR_TS_LO) ? wr_data : r_ts_lower;
      r_ts_upper <= (w_wr && addr == ADDR_TS_HI) ? wr_data : r_ts_upper;
    end
  always_ff @(posedge clkx8)
    if (reset || w_clear || w_flush) begin
      r_overflow <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (w_push & w_full);
      r_late     <= r_late | ((r_state == WAIT) & w_late);
    end
  // head_data doubles as the shift register: the next slice is always in its top bits
  always_ff @(posedge clkx8)
    if (reset) begin
      r_state     <= IDLE;
      r_head_ts   <= '0;
      r_head_data <= '0;
      r_idx       <= '0;
      dout        <= '0;
    end else if (w_flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: r_state <= w_empty ? IDLE : LOAD;
        LOAD: begin
          r_head_ts   <= {w_head.ts_upper, w_head.ts_lower};
          r_head_data <= w_head.data;
          r_state     <= WAIT;
        end
        WAIT:
          if (w_late) r_state <= IDLE;
          else if (w_fire) begin
            dout        <= r_head_data[31 -: N_OUT];
            r_head_data <= r_head_data << N_OUT;
            r_idx       <= IW'(1);
            r_state     <= NSLICE > 1 ? SHIFT : IDLE;
          end
        SHIFT: begin
          dout        <= r_head_data[31 -: N_OUT];
          r_head_data <= r_head_data << N_OUT;
          r_idx       <= r_idx + 1'b1;
          r_state     <= r_idx == IW'(NSLICE - 1) ? IDLE : SHIFT;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
